// File: rtl/mac_frame_serializer.sv
// GMII transmit serializer: preamble/SFD, word-to-byte data, zero pad and optional FCS.
// Define MAC_TX_FCS_EN to append an IEEE 802.3 CRC-32 FCS; undefined builds carry no CRC logic.
module mac_frame_serializer #(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned MIN_DATA_BYTES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_data_in,
  input  logic [1:0]  src_be_in,
  input  logic        src_data_rdy,
  output logic        src_data_sel,
  output logic        src_data_rd,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        tx_busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [15:0] MIN_BYTES = 16'(MIN_DATA_BYTES);
  localparam logic [15:0] IFG_LAST  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [1:0]  last_idx_q, last_idx_d;
  logic        last_q, last_d;
  logic [31:0] word_q, word_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] ifg_cnt_q, ifg_cnt_d;
  logic        sel_q, sel_d;
  logic [7:0]  txd_c;
  logic [7:0]  data_byte;
  logic        to_fcs;

  always_comb begin
    data_byte = 8'h00;
    case (byte_idx_q)
      2'd0: data_byte = word_q[31:24];
      2'd1: data_byte = word_q[23:16];
      2'd2: data_byte = word_q[15:8];
      2'd3: data_byte = word_q[7:0];
      default: data_byte = 8'h00;
    endcase
  end

`ifdef MAC_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [1:0]  fcs_idx_q, fcs_idx_d;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs_word = ~crc_q;
  assign to_fcs   = 1'b1;

  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (fcs_idx_q)
      2'd0: fcs_byte = fcs_word[7:0];
      2'd1: fcs_byte = fcs_word[15:8];
      2'd2: fcs_byte = fcs_word[23:16];
      2'd3: fcs_byte = fcs_word[31:24];
      default: fcs_byte = fcs_word[7:0];
    endcase
  end

  always_comb begin
    crc_d = crc_q;
    case (state_q)
      S_SFD:         crc_d = '1;
      S_DATA, S_PAD: crc_d = crc32_byte(crc_q, txd_c);
      default:       crc_d = crc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q     <= '0;
      fcs_idx_q <= '0;
    end else begin
      crc_q     <= crc_d;
      fcs_idx_q <= fcs_idx_d;
    end
  end
`else
  assign to_fcs = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_idx_d   = byte_idx_q;
    last_idx_d   = last_idx_q;
    last_d       = last_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    ifg_cnt_d    = ifg_cnt_q;
    sel_d        = sel_q;
    txd_c        = 8'h00;
    gmii_tx_en   = 1'b0;
    src_data_rd  = 1'b0;
    tx_done      = 1'b0;
`ifdef MAC_TX_FCS_EN
    fcs_idx_d    = fcs_idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (src_data_rdy) begin
          state_d    = S_PREAMBLE;
          pre_cnt_d  = '0;
          byte_cnt_d = '0;
          sel_d      = 1'b1;
        end
      end

      S_PREAMBLE: begin
        gmii_tx_en = 1'b1;
        txd_c      = 8'h55;
        if (pre_cnt_q == 3'd6) state_d = S_SFD;
        else                   pre_cnt_d = pre_cnt_q + 3'd1;
      end

      S_SFD: begin
        gmii_tx_en  = 1'b1;
        txd_c       = 8'hD5;
        src_data_rd = 1'b1;
        word_d      = src_data_in;
        last_d      = (src_be_in != 2'b00);
        last_idx_d  = (src_be_in == 2'b00) ? 2'd3 : (src_be_in - 2'd1);
        byte_idx_d  = '0;
        state_d     = S_DATA;
      end

      S_DATA: begin
        gmii_tx_en = 1'b1;
        txd_c      = data_byte;
        byte_cnt_d = byte_cnt_q + 16'd1;
        if (byte_idx_q != last_idx_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
        end else if (!last_q && src_data_rdy) begin
          src_data_rd = 1'b1;
          word_d      = src_data_in;
          last_d      = (src_be_in != 2'b00);
          last_idx_d  = (src_be_in == 2'b00) ? 2'd3 : (src_be_in - 2'd1);
          byte_idx_d  = '0;
        end else begin
          // Final word drained (explicit last or source underrun).
          sel_d = 1'b0;
          if ((byte_cnt_q + 16'd1) < MIN_BYTES) begin
            state_d = S_PAD;
          end else if (to_fcs) begin
            state_d = S_FCS;
`ifdef MAC_TX_FCS_EN
            fcs_idx_d = '0;
`endif
          end else begin
            state_d   = S_IFG;
            ifg_cnt_d = '0;
          end
        end
      end

      S_PAD: begin
        gmii_tx_en = 1'b1;
        txd_c      = 8'h00;
        byte_cnt_d = byte_cnt_q + 16'd1;
        if ((byte_cnt_q + 16'd1) >= MIN_BYTES) begin
          if (to_fcs) begin
            state_d = S_FCS;
`ifdef MAC_TX_FCS_EN
            fcs_idx_d = '0;
`endif
          end else begin
            state_d   = S_IFG;
            ifg_cnt_d = '0;
          end
        end
      end

      S_FCS: begin
`ifdef MAC_TX_FCS_EN
        gmii_tx_en = 1'b1;
        txd_c      = fcs_byte;
        if (fcs_idx_q == 2'd3) begin
          state_d   = S_IFG;
          ifg_cnt_d = '0;
        end else begin
          fcs_idx_d = fcs_idx_q + 2'd1;
        end
`else
        state_d   = S_IFG;
        ifg_cnt_d = '0;
`endif
      end

      S_IFG: begin
        tx_done = (ifg_cnt_q == 16'd0);
        if (ifg_cnt_q >= IFG_LAST) state_d = S_IDLE;
        else                       ifg_cnt_d = ifg_cnt_q + 16'd1;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      byte_idx_q <= '0;
      last_idx_q <= '0;
      last_q     <= 1'b0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      ifg_cnt_q  <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_idx_q <= byte_idx_d;
      last_idx_q <= last_idx_d;
      last_q     <= last_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      sel_q      <= sel_d;
    end
  end

  assign gmii_txd     = txd_c;
  assign src_data_sel = sel_q;
  assign tx_busy      = (state_q != S_IDLE);

endmodule

// File: doc/mac_frame_serializer.md
MAC_FRAME_SERIALIZER -- requirements
Module: mac_frame_serializer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  IFG_CYCLES, 12, idle cycles after each frame.
  MIN_DATA_BYTES, 60, minimum data+pad bytes before FCS.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic rising-edge.
  rst  in  1  synchronous reset, active-high.
  src_data_in  in  32  source word; byte 0 = bits [31:24], sent first.
  src_be_in  in  2  valid-byte code: 00 = 4 bytes (not last); 01/10/11 = 1/2/3 bytes (last word).
  src_data_rdy  in  1  source has a frame/word available.
  src_data_sel  out  1  source selected for the current frame.
  src_data_rd  out  1  one-cycle pulse; current word consumed at this edge.
  gmii_txd  out  8  transmit byte.
  gmii_tx_en  out  1  transmit enable.
  tx_busy  out  1  high in every state except IDLE.
  tx_done  out  1  one-cycle pulse at frame end.

Function
REQ-003 FSM states SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS and IFG.
REQ-004 In IDLE with src_data_rdy=1 at an edge, the block SHALL enter PREAMBLE and assert src_data_sel and tx_busy from the next cycle.
REQ-005 PREAMBLE SHALL drive 0x55 for 7 cycles; SFD SHALL drive 0xD5 for 1 cycle; gmii_tx_en=1 in PREAMBLE through FCS.
REQ-006 src_data_rd SHALL pulse in the SFD cycle to capture the first word, and in the cycle each word's last transmitted byte is driven to capture the next word, never otherwise.
REQ-007 DATA SHALL drive the valid bytes of each captured word in order [31:24], [23:16], [15:8], [7:0].
REQ-008 A word with src_be_in≠00 SHALL be the last word; only its first 1/2/3 bytes SHALL be sent, and no further src_data_rd SHALL be issued.
REQ-009 At a word boundary, if the word is not last and src_data_rdy=0, the frame SHALL end after that word, without src_data_rd (underrun end).
REQ-010 src_data_sel SHALL deassert the cycle after the last word is known consumed.
REQ-011 A 16-bit byte counter SHALL count data+pad bytes; if the count at data end is < MIN_DATA_BYTES, PAD SHALL drive 0x00 until the count equals MIN_DATA_BYTES.
REQ-012 If MAC_TX_FCS_EN is defined, FCS SHALL follow DATA/PAD for 4 cycles; otherwise FCS SHALL be skipped.
REQ-013 IFG SHALL hold gmii_tx_en=0 and gmii_txd=0x00 for IFG_CYCLES cycles, then return to IDLE.
REQ-014 tx_done SHALL pulse in the first IFG cycle.
REQ-015 src_data_rdy in IFG SHALL be ignored; back-to-back frames SHALL be separated by exactly IFG_CYCLES+1 idle cycles.
REQ-016 gmii_txd SHALL be 0x00 whenever gmii_tx_en=0.

Reset
REQ-017 On rst=1 at an edge, the FSM SHALL go to IDLE and all counters and the CRC SHALL clear.
REQ-018 On reset, all outputs SHALL be 0: gmii_txd, gmii_tx_en, src_data_sel, src_data_rd, tx_busy, tx_done.
REQ-019 Reset mid-frame SHALL drop gmii_tx_en at that edge with no FCS, no tx_done and no IFG.

Configuration
REQ-020 With MAC_TX_FCS_EN defined, the block SHALL run an IEEE 802.3 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over data+pad bytes; the SFD byte SHALL reset the CRC.
REQ-021 The FCS SHALL be the complemented CRC, sent least-significant byte first.
REQ-022 Without MAC_TX_FCS_EN, no CRC logic SHALL be synthesized and the frame SHALL end after DATA/PAD.

Verification
REQ-023 14-byte header source (3 words be=00 plus 1 word be=10), FCS on -> tx_en high 72 cycles (7×0x55, 0xD5, 14 data, 46×0x00, 4 FCS); 4 rd pulses; tx_done once.
REQ-024 FCS check, FCS on: CRC over the 64 received data+pad+FCS bytes SHALL leave residue 0xC704DD7B; FCS off: same stimulus -> tx_en 68 cycles.
REQ-025 64-byte source (16 words, last be=00, then rdy=0) -> no PAD; 64 data bytes; underrun end; 16 rd pulses.
REQ-026 Last word be=01 after 15 full words -> 61 data bytes; no PAD; only byte [31:24] of the last word sent.
REQ-027 src_data_rdy held high for 2 frames -> gap between tx_en fall and the next tx_en rise is exactly 13 cycles with IFG_CYCLES=12.
REQ-028 rst pulsed during DATA byte 20 -> next cycle tx_en=0, sel=0, busy=0, tx_done=0; a new frame then starts normally.
